// File: rtl/ft2232h_fifo_arbiter.sv
// Arbiter for the shared FT2232H synchronous-FIFO bus: alternates host reads and host writes.
// Optional byte statistics counters are built when FT_ARB_STATS_EN is defined.
module ft2232h_fifo_arbiter #(
  parameter int RX_BURST_MAX = 16,
  parameter int TX_BURST_MAX = 64,
  parameter int TURNAROUND   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rxf_i,
  input  logic        txe_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        data_oe_o,
  output logic        oe_o,
  output logic        rd_o,
  output logic        wr_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [2:0]  state_o,
  output logic [15:0] rx_count_o,
  output logic [15:0] tx_count_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_OE    = 3'd1,
    S_RX_READ  = 3'd2,
    S_TX_WRITE = 3'd3,
    S_TURN     = 3'd4
  } state_t;

  localparam logic [7:0] RX_MAX    = 8'(RX_BURST_MAX);
  localparam logic [7:0] TX_MAX    = 8'(TX_BURST_MAX);
  localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
  localparam logic       DIR_RX    = 1'b0;
  localparam logic       DIR_TX    = 1'b1;

  state_t      state_q, state_d;
  logic        last_dir_q, last_dir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  turn_q, turn_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_req, tx_req, rx_xfer, tx_xfer;

  // Handshakes: an RX byte moves on an edge where rd_o is low (rx_ready_i promised room
  // for it); a TX byte is consumed on an edge where tx_ready_o is high (= wr_o low).
  always_comb begin
    rx_req     = !rxf_i && rx_ready_i;
    tx_req     = !txe_i && tx_valid_i;
    rx_xfer    = (state_q == S_RX_READ) && rx_req && (cnt_q < RX_MAX);
    tx_xfer    = (state_q == S_TX_WRITE) && tx_req && (cnt_q < TX_MAX);
    state_d    = state_q;
    last_dir_d = last_dir_q;
    cnt_d      = cnt_q;
    turn_d     = turn_q;
    rx_data_d  = rx_xfer ? data_i : rx_data_q;
    rx_valid_d = rx_xfer;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_req && (!tx_req || last_dir_q == DIR_TX)) state_d = S_RX_OE;
        else if (tx_req)                                  state_d = S_TX_WRITE;
      end
      S_RX_OE: state_d = S_RX_READ;
      S_RX_READ: begin
        if (rx_xfer) cnt_d = cnt_q + 8'd1;
        else begin
          state_d    = S_TURN;
          last_dir_d = DIR_RX;
          turn_d     = '0;
        end
      end
      S_TX_WRITE: begin
        if (tx_xfer) cnt_d = cnt_q + 8'd1;
        else begin
          state_d    = S_TURN;
          last_dir_d = DIR_TX;
          turn_d     = '0;
        end
      end
      S_TURN: begin
        if (turn_q == TURN_LAST) state_d = S_IDLE;
        else                     turn_d  = turn_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      last_dir_q <= DIR_TX;
      cnt_q      <= '0;
      turn_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      cnt_q      <= cnt_d;
      turn_q     <= turn_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Strobes are decoded straight from the registered state so reset releases the bus at once.
  assign oe_o       = !((state_q == S_RX_OE) || (state_q == S_RX_READ));
  assign rd_o       = !rx_xfer;
  assign wr_o       = !tx_xfer;
  assign tx_ready_o = tx_xfer;
  assign data_oe_o  = (state_q == S_TX_WRITE);
  assign data_o     = (state_q == S_TX_WRITE) ? tx_data_i : 8'h00;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign state_o    = state_q;

`ifdef FT_ARB_STATS_EN
  logic [15:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;

  always_comb begin
    rx_count_d = rx_xfer ? rx_count_q + 16'd1 : rx_count_q;
    tx_count_d = tx_xfer ? tx_count_q + 16'd1 : tx_count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_count_q <= '0;
      tx_count_q <= '0;
    end else begin
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign rx_count_o = rx_count_q;
  assign tx_count_o = tx_count_q;
`else
  assign rx_count_o = 16'h0000;
  assign tx_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_ft2232h_fifo_arbiter.sv
// Directed bench for ft2232h_fifo_arbiter: per-cycle vector table plus reset and fairness sequences.
module tb_ft2232h_fifo_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rxf_i = 1'b1;
  logic        txe_i = 1'b1;
  logic [7:0]  data_i = 8'h00;
  logic [7:0]  data_o;
  logic        data_oe_o, oe_o, rd_o, wr_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b1;
  logic [7:0]  tx_data_i = 8'h00;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [2:0]  state_o;
  logic [15:0] rx_count_o, tx_count_o;

  ft2232h_fifo_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .rxf_i(rxf_i), .txe_i(txe_i),
    .data_i(data_i), .data_o(data_o), .data_oe_o(data_oe_o),
    .oe_o(oe_o), .rd_o(rd_o), .wr_o(wr_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .state_o(state_o), .rx_count_o(rx_count_o), .tx_count_o(tx_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int rx_n = 0;
  int tx_n = 0;

  typedef struct {
    logic       rxf, txe, rdy, tv;
    logic [7:0] din, tdat;
    logic [2:0] st;
    logic       oe, rd, wr, doe, rxv;
    logic [7:0] rxd, dout;
    logic       txr;
  } vec_t;

  vec_t vq[$];

  // Transfer model: a low strobe seen mid-cycle means a byte moves on the next rising edge.
  always @(negedge clk_i) begin
    #2;
    if (!rst_i && !rd_o) rx_n++;
    if (!rst_i && !wr_o) tx_n++;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rxf, txe, rdy, tv, input logic [7:0] din, tdat,
                     input logic [2:0] st, input logic oe, rd, wr, doe, rxv,
                     input logic [7:0] rxd, dout, input logic txr);
    vec_t v;
    v.rxf = rxf; v.txe = txe; v.rdy = rdy; v.tv = tv; v.din = din; v.tdat = tdat;
    v.st = st; v.oe = oe; v.rd = rd; v.wr = wr; v.doe = doe; v.rxv = rxv;
    v.rxd = rxd; v.dout = dout; v.txr = txr;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    rxf_i = 1'b1; txe_i = 1'b1; rx_ready_i = 1'b1; tx_valid_i = 1'b0;
    data_i = 8'h00; tx_data_i = 8'h00;
    repeat (2) @(negedge clk_i);
    rx_n = 0;
    tx_n = 0;
    rst_i = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef FT_ARB_STATS_EN
    chk({tag, " rx_count"}, rx_count_o, 16'(rx_n));
    chk({tag, " tx_count"}, tx_count_o, 16'(tx_n));
`else
    chk({tag, " rx_count"}, rx_count_o, 16'h0000);
    chk({tag, " tx_count"}, tx_count_o, 16'h0000);
`endif
  endtask

  initial begin
    int bdir[$];
    int blen[$];
    int cur;
    logic [2:0] prev;

    // rxf txe rdy tv din  tdat  st oe rd wr doe rxv rxd  dout txr
    // five-byte host read
    add(1,1,1,0,8'h00,8'h00, 0,1,1,1,0,0,8'h00,8'h00,0);
    add(0,1,1,0,8'h11,8'h00, 0,1,1,1,0,0,8'h00,8'h00,0);
    add(0,1,1,0,8'h11,8'h00, 1,0,1,1,0,0,8'h00,8'h00,0);
    add(0,1,1,0,8'h11,8'h00, 2,0,0,1,0,0,8'h00,8'h00,0);
    add(0,1,1,0,8'h12,8'h00, 2,0,0,1,0,1,8'h11,8'h00,0);
    add(0,1,1,0,8'h13,8'h00, 2,0,0,1,0,1,8'h12,8'h00,0);
    add(0,1,1,0,8'h14,8'h00, 2,0,0,1,0,1,8'h13,8'h00,0);
    add(0,1,1,0,8'h15,8'h00, 2,0,0,1,0,1,8'h14,8'h00,0);
    add(1,1,1,0,8'h00,8'h00, 2,0,1,1,0,1,8'h15,8'h00,0);
    add(1,1,1,0,8'h00,8'h00, 4,1,1,1,0,0,8'h15,8'h00,0);
    add(1,1,1,0,8'h00,8'h00, 0,1,1,1,0,0,8'h15,8'h00,0);
    // write, txe_i rises after three bytes, then resumes with byte 4
    add(1,0,1,1,8'h00,8'hA1, 0,1,1,1,0,0,8'h15,8'h00,0);
    add(1,0,1,1,8'h00,8'hA1, 3,1,1,0,1,0,8'h15,8'hA1,1);
    add(1,0,1,1,8'h00,8'hA2, 3,1,1,0,1,0,8'h15,8'hA2,1);
    add(1,0,1,1,8'h00,8'hA3, 3,1,1,0,1,0,8'h15,8'hA3,1);
    add(1,1,1,1,8'h00,8'hA4, 3,1,1,1,1,0,8'h15,8'hA4,0);
    add(1,1,1,1,8'h00,8'hA4, 4,1,1,1,0,0,8'h15,8'h00,0);
    add(1,0,1,1,8'h00,8'hA4, 0,1,1,1,0,0,8'h15,8'h00,0);
    add(1,0,1,1,8'h00,8'hA4, 3,1,1,0,1,0,8'h15,8'hA4,1);
    add(1,0,1,0,8'h00,8'hA5, 3,1,1,1,1,0,8'h15,8'hA5,0);
    add(1,0,1,0,8'h00,8'h00, 4,1,1,1,0,0,8'h15,8'h00,0);
    add(1,1,1,0,8'h00,8'h00, 0,1,1,1,0,0,8'h15,8'h00,0);
    // sink stalls after two bytes, re-grant when it recovers
    add(0,1,1,0,8'h21,8'h00, 0,1,1,1,0,0,8'h15,8'h00,0);
    add(0,1,1,0,8'h21,8'h00, 1,0,1,1,0,0,8'h15,8'h00,0);
    add(0,1,1,0,8'h21,8'h00, 2,0,0,1,0,0,8'h15,8'h00,0);
    add(0,1,1,0,8'h22,8'h00, 2,0,0,1,0,1,8'h21,8'h00,0);
    add(0,1,0,0,8'h23,8'h00, 2,0,1,1,0,1,8'h22,8'h00,0);
    add(0,1,0,0,8'h23,8'h00, 4,1,1,1,0,0,8'h22,8'h00,0);
    add(0,1,0,0,8'h23,8'h00, 0,1,1,1,0,0,8'h22,8'h00,0);
    add(0,1,1,0,8'h23,8'h00, 0,1,1,1,0,0,8'h22,8'h00,0);
    add(1,1,1,0,8'h23,8'h00, 1,0,1,1,0,0,8'h22,8'h00,0);
    add(1,1,1,0,8'h00,8'h00, 2,0,1,1,0,0,8'h22,8'h00,0);
    add(1,1,1,0,8'h00,8'h00, 4,1,1,1,0,0,8'h22,8'h00,0);
    // tie after an RX grant goes to TX, next tie goes to RX
    add(0,0,1,1,8'h00,8'hB0, 0,1,1,1,0,0,8'h22,8'h00,0);
    add(0,0,1,1,8'h00,8'hB0, 3,1,1,0,1,0,8'h22,8'hB0,1);
    add(0,1,1,0,8'h00,8'hB1, 3,1,1,1,1,0,8'h22,8'hB1,0);
    add(0,1,1,0,8'h00,8'h00, 4,1,1,1,0,0,8'h22,8'h00,0);
    add(0,0,1,1,8'h00,8'h00, 0,1,1,1,0,0,8'h22,8'h00,0);
    add(1,1,1,0,8'h00,8'h00, 1,0,1,1,0,0,8'h22,8'h00,0);
    add(1,1,1,0,8'h00,8'h00, 2,0,1,1,0,0,8'h22,8'h00,0);
    add(1,1,1,0,8'h00,8'h00, 4,1,1,1,0,0,8'h22,8'h00,0);
    add(1,1,1,0,8'h00,8'h00, 0,1,1,1,0,0,8'h22,8'h00,0);

    // reset values while reset is held
    #1;
    chk("rst state", 16'(state_o), 16'h0);
    chk("rst oe", 16'(oe_o), 16'h1);
    chk("rst rd", 16'(rd_o), 16'h1);
    chk("rst wr", 16'(wr_o), 16'h1);
    chk("rst data_oe", 16'(data_oe_o), 16'h0);
    chk("rst data_o", 16'(data_o), 16'h0);
    chk("rst rx_data", 16'(rx_data_o), 16'h0);
    chk("rst rx_valid", 16'(rx_valid_o), 16'h0);
    do_reset();

    foreach (vq[i]) begin
      @(negedge clk_i);
      rxf_i = vq[i].rxf; txe_i = vq[i].txe; rx_ready_i = vq[i].rdy; tx_valid_i = vq[i].tv;
      data_i = vq[i].din; tx_data_i = vq[i].tdat;
      #1;
      chk($sformatf("row%0d state", i), 16'(state_o), 16'(vq[i].st));
      chk($sformatf("row%0d oe", i), 16'(oe_o), 16'(vq[i].oe));
      chk($sformatf("row%0d rd", i), 16'(rd_o), 16'(vq[i].rd));
      chk($sformatf("row%0d wr", i), 16'(wr_o), 16'(vq[i].wr));
      chk($sformatf("row%0d data_oe", i), 16'(data_oe_o), 16'(vq[i].doe));
      chk($sformatf("row%0d rx_valid", i), 16'(rx_valid_o), 16'(vq[i].rxv));
      chk($sformatf("row%0d rx_data", i), 16'(rx_data_o), 16'(vq[i].rxd));
      chk($sformatf("row%0d data_o", i), 16'(data_o), 16'(vq[i].dout));
      chk($sformatf("row%0d tx_ready", i), 16'(tx_ready_o), 16'(vq[i].txr));
    end
    check_stats("table");

    // reset asserted in the middle of a write burst
    @(negedge clk_i);
    rxf_i = 1'b1; txe_i = 1'b0; tx_valid_i = 1'b1; tx_data_i = 8'h5A;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i); #1;
      if (state_o == 3'd3) break;
    end
    chk("mid tx state", 16'(state_o), 16'h3);
    chk("mid tx wr", 16'(wr_o), 16'h0);
    rst_i = 1'b1;
    #1;
    chk("async rst wr", 16'(wr_o), 16'h1);
    chk("async rst data_oe", 16'(data_oe_o), 16'h0);
    chk("async rst state", 16'(state_o), 16'h0);
    chk("async rst data_o", 16'(data_o), 16'h0);
    chk("async rst rx_data", 16'(rx_data_o), 16'h0);
    chk("async rst tx_ready", 16'(tx_ready_o), 16'h0);
    rxf_i = 1'b0; rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_n = 0;
    tx_n = 0;
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    chk("first grant rx", 16'(state_o), 16'h1);

    // both directions request continuously: bursts must alternate at full length
    cur = 0;
    prev = state_o;
    for (int c = 0; c < 1000 && blen.size() < 4; c++) begin
      @(negedge clk_i); #1;
      if (state_o == 3'd4 && prev == 3'd2) begin bdir.push_back(0); blen.push_back(cur); cur = 0; end
      if (state_o == 3'd4 && prev == 3'd3) begin bdir.push_back(1); blen.push_back(cur); cur = 0; end
      if (prev == 3'd4) chk("turn length", 16'(state_o), 16'h0);
      if (!rd_o || !wr_o) cur++;
      prev = state_o;
    end
    chk("burst count", 16'(blen.size()), 16'd4);
    foreach (blen[i]) begin
      chk($sformatf("burst%0d dir", i), 16'(bdir[i]), 16'(i % 2));
      chk($sformatf("burst%0d len", i), 16'(blen[i]), (i % 2) ? 16'd64 : 16'd16);
    end
    check_stats("alternate");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft2232h_fifo_arbiter.md
Name: ft2232h_fifo_arbiter

Overview:
Sequences the shared 8-bit FT2232H synchronous-FIFO bus between two directions: host-to-FPGA reads (commands, LED/config bytes) and FPGA-to-host writes (DAQ sample stream).
- Owns oe_o, rd_o, wr_o and the FPGA bus-driver enable.
- Guarantees no bus contention and fair alternation between directions.
- Presents a simple valid/ready byte interface to the internal RX consumer and TX producer.

Parameters:
RX_BURST_MAX, 16, max bytes read per RX grant before re-arbitration (1..255)
TX_BURST_MAX, 64, max bytes written per TX grant before re-arbitration (1..255)
TURNAROUND, 1, idle bus cycles after every grant ends (1..15)

Ports:
clk_i  in  1  60 MHz CLKOUT from FT2232H; all logic on rising edge
rst_i  in  1  asynchronous reset, active-high
rxf_i  in  1  FT RX-FIFO-not-empty, active-low
txe_i  in  1  FT TX-FIFO-not-full, active-low
data_i  in  8  FT bus, input path
data_o  out  8  FT bus, output path
data_oe_o  out  1  1 = FPGA drives the FT bus
oe_o  out  1  FT output enable, active-low
rd_o  out  1  FT read strobe, active-low
wr_o  out  1  FT write strobe, active-low
rx_data_o  out  8  byte read from host
rx_valid_o  out  1  one-cycle strobe per received byte
rx_ready_i  in  1  sink can accept a byte on the next cycle
tx_data_i  in  8  byte to send to host
tx_valid_i  in  1  producer has a byte
tx_ready_o  out  1  byte on tx_data_i is consumed this cycle
state_o  out  3  current state encoding, debug
rx_count_o  out  16  received byte count (optional feature)
tx_count_o  out  16  sent byte count (optional feature)

Behaviour:
- Reset, asynchronous, any time including mid-burst:
  - state = IDLE; last_dir = TX, so RX wins the first tie.
  - oe_o = rd_o = wr_o = 1; data_oe_o = 0; data_o = 0.
  - rx_data_o = 0; rx_valid_o = 0; burst counter = 0; stats counters = 0.
- States and encodings: IDLE=0, RX_OE=1, RX_READ=2, TX_WRITE=3, TURN=4.
- Eligibility:
  - rx_req = !rxf_i && rx_ready_i
  - tx_req = !txe_i && tx_valid_i
- IDLE:
  - rx_req only -> RX_OE.
  - tx_req only -> TX_WRITE.
  - Both -> direction opposite to last_dir.
  - Neither -> stay in IDLE.
  - Burst counter is cleared on grant.
- RX_OE: oe_o = 0 for exactly 1 cycle (FT turns the bus around), rd_o = 1 -> RX_READ.
- RX_READ:
  - oe_o = 0.
  - rd_o (combinational) = !(rx_req && cnt < RX_BURST_MAX).
  - Transfer happens on every rising edge with rd_o = 0 and rxf_i = 0. That edge registers data_i into rx_data_o, pulses rx_valid_o next cycle (latency 1), and increments cnt.
  - Exit to TURN when rd_o would be 1, i.e. on rxf_i high, rx_ready_i low, or cnt == RX_BURST_MAX. Set last_dir = RX.
- TX_WRITE:
  - data_oe_o = 1; data_o = tx_data_i.
  - wr_o (combinational) = !(tx_req && cnt < TX_BURST_MAX); tx_ready_o = !wr_o.
  - Transfer on every rising edge with wr_o = 0; cnt increments.
  - Exit to TURN on txe_i high, tx_valid_i low, or cnt == TX_BURST_MAX. Set last_dir = TX.
- TURN:
  - oe_o = rd_o = wr_o = 1; data_oe_o = 0 for TURNAROUND cycles, then IDLE.
- Bus-contention invariants:
  - data_oe_o = 1 implies oe_o = 1.
  - rd_o = 0 implies oe_o = 0.
  - rd_o and wr_o are never both 0.
- rx_valid_o is never asserted outside the cycle after an RX transfer.
- tx_ready_o = 0 in every state except TX_WRITE.
- Starvation bound:
  - With both directions continuously requesting, grants strictly alternate RX, TX, RX, …
  - Each RX grant is RX_BURST_MAX bytes; each TX grant is TX_BURST_MAX bytes.
- A flag deasserted mid-burst (rxf_i or txe_i going high) ends the burst at that edge; no byte transfers at that edge.

Optional Feature:
FT_ARB_STATS_EN
- Defined:
  - rx_count_o increments on each RX transfer; tx_count_o increments on each TX transfer.
  - Both are 16-bit, wrap 0xFFFF -> 0x0000, and are cleared only by rst_i.
- Undefined: both ports are tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset asserted mid TX_WRITE with wr_o = 0 -> same cycle: wr_o = 1, data_oe_o = 0, state_o = 0; after release, the first grant goes to RX if both request.
- rxf_i low for 5 bytes (0x11..0x15), rx_ready_i = 1 -> oe_o low 1 cycle before rd_o; rx_valid_o pulses 5 times with 0x11..0x15, each 1 cycle after its rd_o-low edge; then TURN for 1 cycle, then IDLE.
- Both directions continuously requesting, defaults -> grant pattern: 16 RX bytes, 1 TURN cycle, 64 TX bytes, 1 TURN cycle, 16 RX bytes, …; never two consecutive same-direction grants.
- txe_i goes high after 3 of 10 TX bytes -> exactly 3 tx_ready_o pulses; wr_o high the same edge txe_i is seen high; when txe_i returns low the write resumes with byte 4.
- rx_ready_i drops after 2 bytes while rxf_i stays low -> rd_o high immediately; no third rx_valid_o; re-grant to RX from IDLE when rx_ready_i returns.
- FT_ARB_STATS_EN defined, 65 537 RX transfers -> rx_count_o = 1; same run without the macro -> rx_count_o = 0.
